// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and helpers.
// Used by the MAC, multiplier and requantiser.
package cnn_pkg;

    localparam int unsigned N_DEF  = 8;
    localparam int unsigned W_DEF  = 5;
    localparam int unsigned K_DEF  = 9;
    localparam int unsigned PROD_W = N_DEF + W_DEF - 1;

    // Ceiling log2 for elaboration-time width math.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
        end
        return r;
    endfunction

    // Clip a signed value into the two's-complement range of 'width' bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int unsigned        width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/mac_requant.sv
// Round-half-up arithmetic right shift followed by signed saturation.
// Purely combinational so pooling stages can reuse it.
module mac_requant
    import cnn_pkg::*;
#(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned SHIFT = 2,
    parameter int unsigned OUT_W = 8
) (
    input  logic [ACC_W-1:0] x_i,
    output logic [OUT_W-1:0] q_c,
    output logic             sat_c
);

    localparam int unsigned RW     = ACC_W + 1;
    localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    logic signed [RW-1:0] r_c;
    logic signed [63:0]   r64_c;
    logic signed [63:0]   clip_c;

    always_comb begin
        r_c = RW'($signed(x_i));
        if (SHIFT > 0) r_c = (r_c + (RW'(1) <<< RND_SH)) >>> SHIFT;
        r64_c  = 64'(r_c);
        clip_c = sat_signed(r64_c, OUT_W);
        q_c    = OUT_W'(clip_c);
        sat_c  = (clip_c != r64_c);
    end

endmodule

// File: rtl/wallace_gen.sv
// Signed N x W multiplier: carry-save reduction of sign-extended partial
// products, with the weight's sign row negated; result wraps to N+W-1 bits.
module wallace_gen
    import cnn_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic [N-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [N+W-2:0] prod_c
);

    localparam int unsigned PW = N + W - 1;

    logic [PW-1:0] a_ext_c;
    logic [PW-1:0] pp_c;
    logic [PW-1:0] sum_c;
    logic [PW-1:0] car_c;
    logic [PW-1:0] nxt_c;

    assign a_ext_c = PW'($signed(a_i));

    // Sign row is added as ~x + 1; the +1 is folded into the final add.
    always_comb begin
        pp_c  = '0;
        sum_c = '0;
        car_c = '0;
        nxt_c = '0;
        for (int unsigned j = 0; j < W; j++) begin
            pp_c = b_i[j] ? (a_ext_c << j) : '0;
            if (j == W - 1) pp_c = ~pp_c;
            nxt_c = sum_c ^ car_c ^ pp_c;
            car_c = ((sum_c & car_c) | (sum_c & pp_c) | (car_c & pp_c)) << 1;
            sum_c = nxt_c;
        end
        prod_c = sum_c + car_c + PW'(1);
    end

endmodule

// File: rtl/conv_mac_accum.sv
// Three-stage streaming MAC: register taps, multiply, accumulate K products
// per window and emit the full sum plus a requantised value.
module conv_mac_accum
    import cnn_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned W     = W_DEF,
    parameter int unsigned K     = K_DEF,
    parameter int unsigned ACC_W = N + W - 1 + clog2(K),
    parameter int unsigned SHIFT = 2,
    parameter int unsigned OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [OUT_W-1:0] out_q,
    output logic             out_sat
);

    localparam int unsigned MUL_W = N + W - 1;
    localparam int unsigned CNT_W = clog2(K);

    logic [N-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             s1_v_q, s1_v_d;
    logic [MUL_W-1:0] prod_q, prod_d;
    logic             s2_v_q, s2_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ov_q, ov_d;
    logic [ACC_W-1:0] oacc_q, oacc_d;
    logic [OUT_W-1:0] oq_q, oq_d;
    logic             osat_q, osat_d;

    logic             en_c;
    logic             last_c;
    logic [MUL_W-1:0] mul_c;
    logic [ACC_W-1:0] acc_next_c;
    logic [OUT_W-1:0] rq_q_c;
    logic             rq_sat_c;

    wallace_gen #(.N(N), .W(W)) u_mul (
        .a_i    (a_q),
        .b_i    (b_q),
        .prod_c (mul_c)
    );

    mac_requant #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rq (
        .x_i   (acc_next_c),
        .q_c   (rq_q_c),
        .sat_c (rq_sat_c)
    );

    assign en_c       = ~ov_q | out_ready;
    assign last_c     = (cnt_q == CNT_W'(K - 1));
    assign acc_next_c = ((cnt_q == '0) ? '0 : acc_q) + ACC_W'($signed(prod_q));

    // The whole pipeline advances together; a held result freezes every stage.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        s1_v_d = s1_v_q;
        prod_d = prod_q;
        s2_v_d = s2_v_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        ov_d   = ov_q;
        oacc_d = oacc_q;
        oq_d   = oq_q;
        osat_d = osat_q;
        if (en_c) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                a_d = in_a;
                b_d = in_b;
            end
            s2_v_d = s1_v_q;
            prod_d = mul_c;
            if (s2_v_q && last_c) begin
                oacc_d = acc_next_c;
                oq_d   = rq_q_c;
                osat_d = rq_sat_c;
                ov_d   = 1'b1;
                cnt_d  = '0;
            end else begin
                if (s2_v_q) begin
                    acc_d = acc_next_c;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (ov_q && out_ready) ov_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            s1_v_q <= 1'b0;
            prod_q <= '0;
            s2_v_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            ov_q   <= 1'b0;
            oacc_q <= '0;
            oq_q   <= '0;
            osat_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            s1_v_q <= s1_v_d;
            prod_q <= prod_d;
            s2_v_q <= s2_v_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            ov_q   <= ov_d;
            oacc_q <= oacc_d;
            oq_q   <= oq_d;
            osat_q <= osat_d;
        end
    end

    assign in_ready  = en_c;
    assign out_valid = ov_q;
    assign out_acc   = oacc_q;
    assign out_q     = oq_q;
    assign out_sat   = osat_q;

endmodule

// File: tb/tb_conv_mac_accum.sv
// Self-checking bench for conv_mac_accum: directed window table, hand-written
// stall/reset sequences and randomized traffic against an arithmetic model.
module tb_conv_mac_accum;

    localparam int N     = 8;
    localparam int W     = 5;
    localparam int K     = 9;
    localparam int ACC_W = 16;
    localparam int SHIFT = 2;
    localparam int OUT_W = 8;
    localparam int PW    = N + W - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [N-1:0]            in_a;
    logic [W-1:0]            in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_acc;
    logic signed [OUT_W-1:0] out_q;
    logic                    out_sat;

    conv_mac_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_q     (out_q),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int tq_a[$], tq_b[$];
    int ex_acc[$], ex_q[$], ex_sat[$];
    int rs_acc[$], rs_q[$], rs_sat[$];
    int m_acc = 0;
    int m_cnt = 0;
    int last_lat = -1;

    typedef struct {
        int ae; int ao; int b; int gap;
        int exp_acc; int exp_q; int exp_sat;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Product as the datapath defines it: exact, then wrapped into PW bits.
    function automatic int wrap_prod(input int a, input int b);
        int p, lim;
        p   = a * b;
        lim = 1 << (PW - 1);
        if (p >= lim)  p -= 2 * lim;
        if (p < -lim)  p += 2 * lim;
        return p;
    endfunction

    task automatic model_tap(input int a, input int b);
        int r, lim, q, s;
        if (m_cnt == 0) m_acc = 0;
        m_acc += wrap_prod(a, b);
        m_cnt++;
        if (m_cnt == K) begin
            r   = (SHIFT > 0) ? ((m_acc + (1 << (SHIFT - 1))) >>> SHIFT) : m_acc;
            lim = 1 << (OUT_W - 1);
            q = r; s = 0;
            if (r > lim - 1) begin q = lim - 1; s = 1; end
            else if (r < -lim) begin q = -lim; s = 1; end
            ex_acc.push_back(m_acc); ex_q.push_back(q); ex_sat.push_back(s);
            m_cnt = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cnt = 0;
        ex_acc.delete(); ex_q.delete(); ex_sat.delete();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_acc",   int'(out_acc),   0);
        check("rst_out_q",     int'(out_q),     0);
        check("rst_out_sat",   int'(out_sat),   0);
        check("rst_in_ready",  int'(in_ready),  1);
    endtask

    // Stream the queued taps and consume n_res results, checking each against the model.
    task automatic run(input int gap_pct, input int stall_len, input bit rand_rdy, input int n_res);
        int idx = 0, got = 0, steps = 0, stall_left = 0, acc_step = -1;
        bit stall_done = 0, lat_pending = 0, v, rdy;
        last_lat = -1;
        while ((idx < tq_a.size() || got < n_res) && steps < 3000) begin
            @(negedge clk);
            if (out_valid && !stall_done && stall_len > 0) begin
                stall_left = stall_len; stall_done = 1;
            end
            rdy = (stall_left == 0) && (!rand_rdy || ($urandom_range(99) < 70));
            if (stall_left > 0) stall_left--;
            v = (idx < tq_a.size()) && ($urandom_range(99) >= gap_pct);
            in_valid = v;
            if (v) begin in_a = N'(tq_a[idx]); in_b = W'(tq_b[idx]); end
            else   begin in_a = N'($urandom); in_b = W'($urandom); end
            out_ready = rdy;
            #1;
            if (out_valid && lat_pending) begin
                last_lat = steps - 1 - acc_step; lat_pending = 0;
            end
            if (out_valid && !rdy) begin
                check("stall_in_ready", int'(in_ready), 0);
                if (ex_acc.size() > 0) begin
                    check("held_acc", int'(out_acc), ex_acc[0]);
                    check("held_q",   int'(out_q),   ex_q[0]);
                end
            end
            if (out_valid && rdy) begin
                check("result_pending", int'(ex_acc.size() > 0), 1);
                if (ex_acc.size() > 0) begin
                    check("out_acc", int'(out_acc), ex_acc.pop_front());
                    check("out_q",   int'(out_q),   ex_q.pop_front());
                    check("out_sat", int'(out_sat), ex_sat.pop_front());
                end
                rs_acc.push_back(int'(out_acc)); rs_q.push_back(int'(out_q));
                rs_sat.push_back(int'(out_sat));
                got++;
            end
            if (v && in_ready) begin
                model_tap(tq_a[idx], tq_b[idx]);
                idx++;
                if (idx == tq_a.size()) begin acc_step = steps; lat_pending = 1; end
            end
            steps++;
            @(posedge clk);
        end
        check("taps_accepted", idx, tq_a.size());
        check("results_seen",  got, n_res);
        tq_a.delete(); tq_b.delete();
    endtask

    task automatic add_taps(input int n, input int ae, input int ao, input int b);
        for (int i = 0; i < n; i++) begin
            tq_a.push_back((i % 2 == 0) ? ae : ao);
            tq_b.push_back(b);
        end
    endtask

    task automatic check_result(input string tag, input int i, input int acc, input int q, input int sat);
        if (rs_acc.size() > i) begin
            check({tag, "_acc"}, rs_acc[i], acc);
            check({tag, "_q"},   rs_q[i],   q);
            check({tag, "_sat"}, rs_sat[i], sat);
        end else begin
            check({tag, "_present"}, rs_acc.size(), i + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        tbl[0] = '{3,    3,    2,   0,  54,     14,   0};
        tbl[1] = '{-128, -128, 15,  0,  -17280, -128, 1};
        tbl[2] = '{-128, -128, -16, 0,  -18432, -128, 1};
        tbl[3] = '{10,   -10,  7,   0,  70,     18,   0};
        tbl[4] = '{10,   -10,  7,   40, 70,     18,   0};
        tbl[5] = '{127,  127,  15,  0,  17145,  127,  1};

        do_reset();

        for (int t = 0; t < 6; t++) begin
            add_taps(K, tbl[t].ae, tbl[t].ao, tbl[t].b);
            run(tbl[t].gap, 0, 1'b0, 1);
            check_result($sformatf("tbl%0d", t), 0, tbl[t].exp_acc, tbl[t].exp_q, tbl[t].exp_sat);
            check($sformatf("tbl%0d_latency", t), last_lat, 2);
            rs_acc.delete(); rs_q.delete(); rs_sat.delete();
        end

        // Back-to-back windows with a 5-cycle consumer stall after the first result.
        add_taps(K, 1, 1, 1);
        add_taps(K, 2, 2, -1);
        run(0, 5, 1'b0, 2);
        check_result("b2b0", 0, 9, 2, 0);
        check_result("b2b1", 1, -18, -4, 0);
        rs_acc.delete(); rs_q.delete(); rs_sat.delete();

        // Reset in the middle of a window discards it entirely.
        add_taps(4, 5, 5, 5);
        run(0, 0, 1'b0, 0);
        do_reset();
        add_taps(K, 1, 1, 1);
        run(0, 0, 1'b0, 1);
        check_result("abort", 0, 9, 2, 0);
        check("abort_count", rs_acc.size(), 1);
        rs_acc.delete(); rs_q.delete(); rs_sat.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            check("no_extra_result", int'(out_valid), 0);
        end

        // Random taps, gaps and back-pressure against the model.
        for (int w = 0; w < 25; w++) begin
            for (int i = 0; i < K; i++) begin
                tq_a.push_back($urandom_range(255) - 128);
                tq_b.push_back($urandom_range(31) - 16);
            end
        end
        run(30, 3, 1'b1, 25);
        check("model_drained", ex_acc.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
